sid_voice_bank_mixer: RTL

- Parametrised register bank and time-multiplexed mixer for NUM_VOICES SID voices.
- Generalises the fixed three-voice wrapper in four ways: configurable voice count, per-voice gain, per-voice mute, and master volume.
- Adds registered readback, a sample-tick-driven mix FSM, and overrun detection.
- Drives flat register buses into external sid_voice instances; mixes their 8-bit outputs into one 8-bit sample for pwm_audio.

---
 rtl/sid_voice_bank_mixer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sid_voice_bank_mixer.sv
// sid_voice_bank_mixer: register bank and time-multiplexed mixer for NUM_VOICES SID voices.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wr_en, voice_sel,
//   reg_addr, wr_data   - register write port (write on rising edge of wr_en)
//   rd_data             - registered readback of (voice_sel, reg_addr)
//   frequency .. waveform - flat per-voice register buses to sid_voice instances
//   voice_in            - per-voice 8-bit outputs from the sid_voice instances
//   sample_tick         - single-cycle request to start a mix pass
//   sample_out, sample_valid - mixed sample and its one-cycle update strobe
//   busy                - mix FSM is not idle
module sid_voice_bank_mixer #(
    parameter int unsigned NUM_VOICES = 3,
    parameter int unsigned MIX_SHIFT  = 2,
    parameter int unsigned VSEL_W     = $clog2(NUM_VOICES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [VSEL_W-1:0]          voice_sel,
    input  logic [2:0]                 reg_addr,
    input  logic [7:0]                 wr_data,
    output logic [7:0]                 rd_data,
    output logic [16*NUM_VOICES-1:0]   frequency,
    output logic [8*NUM_VOICES-1:0]    duration,
    output logic [8*NUM_VOICES-1:0]    attack,
    output logic [8*NUM_VOICES-1:0]    sustain,
    output logic [8*NUM_VOICES-1:0]    waveform,
    input  logic [8*NUM_VOICES-1:0]    voice_in,
    input  logic                       sample_tick,
    output logic [7:0]                 sample_out,
    output logic                       sample_valid,
    output logic                       busy
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned ACC_W = 8 + $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

    logic [15:0]           freq_q  [NUM_VOICES];
    logic [7:0]            dur_q   [NUM_VOICES];
    logic [7:0]            gain_q  [NUM_VOICES];
    logic [7:0]            atk_q   [NUM_VOICES];
    logic [7:0]            sus_q   [NUM_VOICES];
    logic [7:0]            wave_q  [NUM_VOICES];
    logic [7:0]            vin     [NUM_VOICES];
    logic [7:0]            master_q;
    logic [NUM_VOICES-1:0] mute_q;
    logic                  overrun_q;
    logic                  wr_q;

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  do_scale;

    logic                  wr_fire;
    logic                  is_voice;
    logic                  is_global;
    logic [IDX_W-1:0]      vidx;
    logic [7:0]            rd_c;
    logic [7:0]            term;
    logic [ACC_W-1:0]      s_wide;
    logic [7:0]            s_sat;
    logic [7:0]            scaled;

    assign wr_fire   = wr_en & ~wr_q;
    assign is_voice  = voice_sel < VSEL_W'(NUM_VOICES);
    assign is_global = voice_sel == VSEL_W'(NUM_VOICES);
    assign vidx      = IDX_W'(voice_sel);

    // Flatten register arrays onto the sid_voice buses; unpack voice inputs.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_flat
        assign frequency[16*i +: 16] = freq_q[i];
        assign duration[8*i +: 8]    = dur_q[i];
        assign attack[8*i +: 8]      = atk_q[i];
        assign sustain[8*i +: 8]     = sus_q[i];
        assign waveform[8*i +: 8]    = wave_q[i];
        assign vin[i]                = voice_in[8*i +: 8];
    end

    // Per-voice contribution and the final scale stage.
    assign term   = mute_q[idx_q] ? 8'd0
                  : 8'((16'(vin[idx_q]) * (16'(gain_q[idx_q]) + 16'd1)) >> 8);
    assign s_wide = acc_q >> MIX_SHIFT;
    assign s_sat  = (s_wide > ACC_W'(255)) ? 8'hFF : s_wide[7:0];
    assign scaled = 8'((16'(s_sat) * (16'(master_q) + 16'd1)) >> 8);

    // Readback mux; registered below so a same-cycle write returns the old value.
    always_comb begin
        rd_c = 8'd0;
        if (is_voice) begin
            case (reg_addr)
                3'd0:    rd_c = freq_q[vidx][7:0];
                3'd1:    rd_c = freq_q[vidx][15:8];
                3'd2:    rd_c = dur_q[vidx];
                3'd3:    rd_c = gain_q[vidx];
                3'd4:    rd_c = atk_q[vidx];
                3'd5:    rd_c = sus_q[vidx];
                3'd6:    rd_c = wave_q[vidx];
                default: rd_c = 8'd0;
            endcase
        end else if (is_global) begin
            case (reg_addr)
                3'd0:    rd_c = master_q;
                3'd1:    rd_c = 8'(mute_q);
                3'd2:    rd_c = {7'd0, overrun_q};
                default: rd_c = 8'd0;
            endcase
        end
    end

    // Mix FSM next-state logic.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        do_scale = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(term);
                if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SCALE: begin
                do_scale = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            idx_q        <= '0;
            sample_out   <= 8'd0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            rd_data      <= 8'd0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            sample_valid <= do_scale;
            busy         <= state_d != IDLE;
            rd_data      <= rd_c;
            if (do_scale) begin
                sample_out <= scaled;
            end
        end
    end

    // Register bank writes; a new overrun beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                freq_q[i] <= 16'd0;
                dur_q[i]  <= 8'd0;
                gain_q[i] <= 8'hFF;
                atk_q[i]  <= 8'd0;
                sus_q[i]  <= 8'd0;
                wave_q[i] <= 8'd0;
            end
            master_q  <= 8'hFF;
            mute_q    <= '0;
            overrun_q <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            wr_q <= wr_en;
            if (wr_fire && is_voice) begin
                case (reg_addr)
                    3'd0:    freq_q[vidx][7:0]  <= wr_data;
                    3'd1:    freq_q[vidx][15:8] <= wr_data;
                    3'd2:    dur_q[vidx]        <= wr_data;
                    3'd3:    gain_q[vidx]       <= wr_data;
                    3'd4:    atk_q[vidx]        <= wr_data;
                    3'd5:    sus_q[vidx]        <= wr_data;
                    3'd6:    wave_q[vidx]       <= wr_data;
                    default: ;
                endcase
            end
            if (wr_fire && is_global) begin
                case (reg_addr)
                    3'd0:    master_q  <= wr_data;
                    3'd1:    mute_q    <= wr_data[NUM_VOICES-1:0];
                    3'd2:    overrun_q <= 1'b0;
                    default: ;
                endcase
            end
            if (sample_tick && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule
